// File: rtl/rda_sum_collector.sv
// Result collector behind the non-stallable pipelined RDA adder: tracks live
// operations through the adder latency, buffers sums with overflow/carry, and grants credits.
module rda_sum_collector #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned LATENCY = 5,
    parameter int unsigned DEPTH   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic             issue_sign_a,
    input  logic             issue_sign_b,
    input  logic [WIDTH-1:0] sum_in,
    input  logic [7:0]       xout_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_ovf,
    output logic             out_cout,
    output logic             err
);

    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned INF_W  = $clog2(LATENCY + 1);
    localparam int unsigned CRD_W  = $clog2(LATENCY + DEPTH + 1);
    localparam logic [7:0]  XOUT_G = 8'h67;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             ovf;
        logic             cout;
    } result_t;

    logic [LATENCY-1:0] tag_vld_q, tag_vld_d;
    logic [LATENCY-1:0] tag_sa_q,  tag_sa_d;
    logic [LATENCY-1:0] tag_sb_q,  tag_sb_d;
    logic [PTR_W-1:0]   wr_ptr_q,  wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q,  rd_ptr_d;
    logic [CNT_W-1:0]   occ_q,     occ_d;
    logic               err_q,     err_d;
    result_t            mem_q [DEPTH];

    logic [INF_W-1:0]   inflight;
    logic               accept;
    logic               capture;
    logic               pop;
    logic               full;
    logic               wr_en;
    result_t            wr_data;
    result_t            head;

    // Credits count both buffered results and operations still inside the adder.
    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < LATENCY; i++) begin
            inflight = inflight + INF_W'(tag_vld_q[i]);
        end
    end

    assign issue_ready = (CRD_W'(inflight) + CRD_W'(occ_q)) < CRD_W'(DEPTH);
    assign accept      = issue_valid && issue_ready;

    assign capture = tag_vld_q[LATENCY-1];
    assign full    = (occ_q == CNT_W'(DEPTH));
    assign pop     = out_valid && out_ready;
    assign wr_en   = capture && (!full || pop);

    assign wr_data.sum  = sum_in;
    assign wr_data.ovf  = (tag_sa_q[LATENCY-1] == tag_sb_q[LATENCY-1]) &&
                          (sum_in[WIDTH-1] != tag_sa_q[LATENCY-1]);
    assign wr_data.cout = (xout_in == XOUT_G);

    // Tag shift register mirrors the adder pipeline, one stage per cycle.
    always_comb begin
        tag_vld_d    = '0;
        tag_sa_d     = '0;
        tag_sb_d     = '0;
        tag_vld_d[0] = accept;
        tag_sa_d[0]  = issue_sign_a;
        tag_sb_d[0]  = issue_sign_b;
        for (int unsigned i = 1; i < LATENCY; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_sa_d[i]  = tag_sa_q[i-1];
            tag_sb_d[i]  = tag_sb_q[i-1];
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        err_d    = err_q;
        if (wr_en) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({wr_en, pop})
            2'b10:   occ_d = occ_q + CNT_W'(1);
            2'b01:   occ_d = occ_q - CNT_W'(1);
            default: occ_d = occ_q;
        endcase
        // A capture into a full FIFO with no pop can only come from a protocol breach.
        if (capture && full && !pop) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_vld_q <= '0;
            tag_sa_q  <= '0;
            tag_sb_q  <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            tag_vld_q <= tag_vld_d;
            tag_sa_q  <= tag_sa_d;
            tag_sb_q  <= tag_sb_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
            err_q     <= err_d;
        end
    end

    // Storage needs no reset; occupancy masks stale entries.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign head      = mem_q[rd_ptr_q];
    assign out_valid = (occ_q != '0);
    assign out_sum   = out_valid ? head.sum  : '0;
    assign out_ovf   = out_valid ? head.ovf  : 1'b0;
    assign out_cout  = out_valid ? head.cout : 1'b0;
    assign err       = err_q;

endmodule

// File: tb/tb_rda_sum_collector.sv
// Bench for rda_sum_collector: a fixed-latency adder stand-in feeds sums, a
// scoreboard queue holds hand-computed results and a negedge monitor checks every pop.
module tb_rda_sum_collector;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned LATENCY = 5;
    localparam int unsigned DEPTH   = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             issue_valid;
    logic             issue_ready;
    logic             issue_sign_a;
    logic             issue_sign_b;
    logic [WIDTH-1:0] sum_in;
    logic [7:0]       xout_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_ovf;
    logic             out_cout;
    logic             err;

    rda_sum_collector #(.WIDTH(WIDTH), .LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .issue_sign_a (issue_sign_a),
        .issue_sign_b (issue_sign_b),
        .sum_in       (sum_in),
        .xout_in      (xout_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sum      (out_sum),
        .out_ovf      (out_ovf),
        .out_cout     (out_cout),
        .err          (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             ovf;
        logic             cout;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Adder stand-in: operands in cycle t give sum and carry status in cycle t+LATENCY.
    logic [WIDTH-1:0] ai = '0;
    logic [WIDTH-1:0] bi = '0;
    logic [WIDTH:0]   add_w;
    logic [WIDTH-1:0] pipe_sum [LATENCY];
    logic [7:0]       pipe_x   [LATENCY];

    assign add_w   = {1'b0, ai} + {1'b0, bi};
    assign sum_in  = pipe_sum[LATENCY-1];
    assign xout_in = pipe_x[LATENCY-1];

    always @(posedge clk) begin
        pipe_sum[0] <= add_w[WIDTH-1:0];
        pipe_x[0]   <= add_w[WIDTH] ? 8'h67 : 8'h6B;
        for (int i = 1; i < LATENCY; i++) begin
            pipe_sum[i] <= pipe_sum[i-1];
            pipe_x[i]   <= pipe_x[i-1];
        end
    end

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every handshake must match the oldest expected result.
    always @(negedge clk) begin
        if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL pop_unexpected: got sum=%0h ovf=%0b cout=%0b, expected no output (t=%0t)",
                         out_sum, out_ovf, out_cout, $time);
            end else begin
                mon_e = exp_q.pop_front();
                if (out_sum !== mon_e.sum || out_ovf !== mon_e.ovf || out_cout !== mon_e.cout) begin
                    n_bad++;
                    $display("FAIL pop_result: got sum=%0h ovf=%0b cout=%0b, expected sum=%0h ovf=%0b cout=%0b (t=%0t)",
                             out_sum, out_ovf, out_cout, mon_e.sum, mon_e.ovf, mon_e.cout, $time);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Present one operation for one cycle; a credit is expected iff rdy_exp.
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] es, input logic eo, input logic ec,
                         input logic rdy_exp);
        ai           = a;
        bi           = b;
        issue_sign_a = a[WIDTH-1];
        issue_sign_b = b[WIDTH-1];
        issue_valid  = 1'b1;
        check("issue_ready_at_issue", WIDTH'(issue_ready), WIDTH'(rdy_exp));
        if (rdy_exp) exp_q.push_back('{sum: es, ovf: eo, cout: ec});
        step();
    endtask

    task automatic idle();
        issue_valid  = 1'b0;
        ai           = '0;
        bi           = '0;
        issue_sign_a = 1'b0;
        issue_sign_b = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"},   WIDTH'(out_valid),   '0);
        check({tag, "_out_sum"},     out_sum,             '0);
        check({tag, "_out_ovf"},     WIDTH'(out_ovf),     '0);
        check({tag, "_out_cout"},    WIDTH'(out_cout),    '0);
        check({tag, "_err"},         WIDTH'(err),         '0);
        check({tag, "_issue_ready"}, WIDTH'(issue_ready), WIDTH'(1));
    endtask

    initial begin
        rst       = 1'b0;
        out_ready = 1'b0;
        idle();
        #2;
        check_reset_outputs("por");
        steps(3);
        rst = 1'b1;
        steps(2);

        // Single op: -10 + 10, carry-out generated.
        out_ready = 1'b1;
        issue(32'hFFFF_FFF6, 32'd10, 32'd0, 1'b0, 1'b1, 1'b1);
        idle();
        steps(4);
        check("single_not_yet_valid", WIDTH'(out_valid), '0);
        step();
        check("single_valid_cycle6", WIDTH'(out_valid), WIDTH'(1));
        check("single_sum", out_sum, 32'd0);
        check("single_cout", WIDTH'(out_cout), WIDTH'(1));
        steps(3);

        // Back-to-back with a ready consumer.
        issue(32'd352, 32'd18, 32'd370, 1'b0, 1'b0, 1'b1);
        issue(32'd4, 32'd10, 32'd14, 1'b0, 1'b0, 1'b1);
        idle();
        check("b2b_ready_c2", WIDTH'(issue_ready), WIDTH'(1));
        steps(4);
        check("b2b_sum_c6", out_sum, 32'd370);
        step();
        check("b2b_sum_c7", out_sum, 32'd14);
        check("b2b_ready_c7", WIDTH'(issue_ready), WIDTH'(1));
        steps(3);

        // Signed overflow in both directions.
        issue(32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b1, 1'b0, 1'b1);
        issue(32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1);
        idle();
        steps(8);

        // Backpressure: only DEPTH credits, then drain in order.
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            issue(32'd100 + 32'(i), 32'(i), 32'd100 + 32'(2 * i), 1'b0, 1'b0, i < 4);
        end
        idle();
        steps(6);
        check("bp_ready_full", WIDTH'(issue_ready), '0);
        check("bp_head_sum", out_sum, 32'd100);
        out_ready = 1'b1;
        check("bp_ready_before_pop", WIDTH'(issue_ready), '0);
        step();
        check("bp_ready_after_pop", WIDTH'(issue_ready), WIDTH'(1));
        steps(5);
        check("bp_drained", WIDTH'(out_valid), '0);
        check("bp_err", WIDTH'(err), '0);

        // Protocol violation: inject a live tag while the FIFO is full.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            issue(32'd200 + 32'(i), 32'(i), 32'd200 + 32'(2 * i), 1'b0, 1'b0, 1'b1);
        end
        idle();
        steps(6);
        check("viol_ready_full", WIDTH'(issue_ready), '0);
        check("viol_err_before", WIDTH'(err), '0);
        force dut.tag_vld_q = 5'b10000;
        step();
        release dut.tag_vld_q;
        steps(2);
        check("viol_err_set", WIDTH'(err), WIDTH'(1));
        check("viol_occ", WIDTH'(dut.occ_q), WIDTH'(4));
        check("viol_head_sum", out_sum, 32'd200);
        out_ready = 1'b1;
        steps(6);
        check("viol_drained", WIDTH'(out_valid), '0);
        check("viol_err_sticky", WIDTH'(err), WIDTH'(1));
        rst = 1'b0;
        #1;
        check("viol_err_cleared", WIDTH'(err), '0);
        step();
        rst = 1'b1;
        steps(2);

        // Asynchronous reset with one result buffered and two still in the adder.
        out_ready = 1'b0;
        issue(32'd1, 32'd2, 32'd3, 1'b0, 1'b0, 1'b1);
        issue(32'd3, 32'd4, 32'd7, 1'b0, 1'b0, 1'b1);
        issue(32'd5, 32'd6, 32'd11, 1'b0, 1'b0, 1'b1);
        idle();
        steps(3);
        check("rst_pre_valid", WIDTH'(out_valid), WIDTH'(1));
        check("rst_pre_sum", out_sum, 32'd3);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("midrst");
        exp_q.delete();
        step();
        rst       = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < int'(LATENCY) + 2; i++) begin
            check("rst_no_stale", WIDTH'(out_valid), '0);
            step();
        end
        check("rst_ready_after", WIDTH'(issue_ready), WIDTH'(1));

        check("scoreboard_empty", WIDTH'(exp_q.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
